// File: rtl/prog_loader.sv
// Nibble-stream program loader: pairs nibbles into bytes and writes them to program memory.
// Optional running checksum enabled by defining LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter logic [11:0] BASE_ADDR = 12'h000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [3:0]  NIB_IN,
  input  logic        NIB_VALID,
  input  logic        NIB_LAST,
  output logic        NIB_READY,
  output logic [11:0] MEM_ADDR,
  output logic [7:0]  MEM_DATA,
  output logic        MEM_WE,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic        CPU_RUN,
  output logic [12:0] BYTE_CNT,
  output logic [7:0]  CHECKSUM
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HI    = 3'd1;
  localparam logic [2:0] S_LO    = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;
  localparam logic [2:0] S_FAIL  = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [11:0] addr_q, addr_d;
  logic [3:0]  hi_q, hi_d;
  logic [7:0]  data_q, data_d;
  logic        last_q, last_d;
  logic [12:0] cnt_q, cnt_d;

  logic idle_like, start_go, nib_acc;

  assign idle_like = (state_q == S_IDLE) || (state_q == S_FIN) || (state_q == S_FAIL);
  assign start_go  = idle_like && START;
  assign NIB_READY = (state_q == S_HI) || (state_q == S_LO);
  assign nib_acc   = NIB_READY && NIB_VALID;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    hi_d    = hi_q;
    data_d  = data_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_FIN, S_FAIL: begin
        if (START) begin
          state_d = S_HI;
          addr_d  = BASE_ADDR;
          cnt_d   = 13'd0;
        end
      end
      S_HI: begin
        if (nib_acc) begin
          // LAST on a high nibble means an odd nibble count: nothing to write
          if (NIB_LAST) begin
            state_d = S_FAIL;
          end else begin
            hi_d    = NIB_IN;
            state_d = S_LO;
          end
        end
      end
      S_LO: begin
        if (nib_acc) begin
          data_d  = {hi_q, NIB_IN};
          last_d  = NIB_LAST;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        cnt_d  = cnt_q + 13'd1;
        addr_d = addr_q + 12'd1;
        // Top of memory without LAST is an overflow; never wrap into a second write
        if (last_q)                  state_d = S_FIN;
        else if (addr_q == 12'hFFF)  state_d = S_FAIL;
        else                         state_d = S_HI;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      addr_q  <= BASE_ADDR;
      hi_q    <= 4'h0;
      data_q  <= 8'h00;
      last_q  <= 1'b0;
      cnt_q   <= 13'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      hi_q    <= hi_d;
      data_q  <= data_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                   csum_q <= 8'h00;
    else if (start_go)          csum_q <= 8'h00;
    else if (state_q == S_WRITE) csum_q <= csum_q + data_q;
  end

  assign CHECKSUM = csum_q;
`else
  assign CHECKSUM = 8'h00;
`endif

  assign MEM_ADDR = addr_q;
  assign MEM_DATA = data_q;
  assign MEM_WE   = (state_q == S_WRITE);
  assign BUSY     = (state_q == S_HI) || (state_q == S_LO) || (state_q == S_WRITE);
  assign DONE     = (state_q == S_FIN);
  assign ERR      = (state_q == S_FAIL);
  assign CPU_RUN  = (state_q == S_FIN);
  assign BYTE_CNT = cnt_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: two instances (base 000 and base FFE) sharing a stimulus mux.
module tb_prog_loader;
  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  nib = 4'h0;
  logic        vld = 1'b0;
  logic        last = 1'b0;
  logic        sel = 1'b0;

  logic        rdy0, we0, busy0, done0, err0, run0;
  logic [11:0] addr0;
  logic [7:0]  data0, cs0;
  logic [12:0] cnt0;
  logic        rdy1, we1, busy1, done1, err1, run1;
  logic [11:0] addr1;
  logic [7:0]  data1, cs1;
  logic [12:0] cnt1;

  logic        rdy, busy, done, err, run;
  logic [12:0] cnt;

  int checks = 0;
  int errors = 0;
  logic [19:0] q0[$];
  logic [19:0] q1[$];

  always #5 CLK = ~CLK;

  prog_loader #(.BASE_ADDR(12'h000)) dut (
    .CLK(CLK), .RST(RST), .START(start & ~sel), .NIB_IN(nib),
    .NIB_VALID(vld & ~sel), .NIB_LAST(last), .NIB_READY(rdy0),
    .MEM_ADDR(addr0), .MEM_DATA(data0), .MEM_WE(we0), .BUSY(busy0),
    .DONE(done0), .ERR(err0), .CPU_RUN(run0), .BYTE_CNT(cnt0), .CHECKSUM(cs0));

  prog_loader #(.BASE_ADDR(12'hFFE)) dut_w (
    .CLK(CLK), .RST(RST), .START(start & sel), .NIB_IN(nib),
    .NIB_VALID(vld & sel), .NIB_LAST(last), .NIB_READY(rdy1),
    .MEM_ADDR(addr1), .MEM_DATA(data1), .MEM_WE(we1), .BUSY(busy1),
    .DONE(done1), .ERR(err1), .CPU_RUN(run1), .BYTE_CNT(cnt1), .CHECKSUM(cs1));

  assign rdy  = sel ? rdy1  : rdy0;
  assign busy = sel ? busy1 : busy0;
  assign done = sel ? done1 : done0;
  assign err  = sel ? err1  : err0;
  assign run  = sel ? run1  : run0;
  assign cnt  = sel ? cnt1  : cnt0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the head of its instance's queue
  always @(negedge CLK) begin
    if (RST && we0) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL wr0_unexpected: got %0h@%0h expected none", data0, addr0);
      end else begin
        logic [19:0] e0;
        e0 = q0.pop_front();
        if ({addr0, data0} !== e0) begin
          errors++;
          $display("FAIL wr0: got %0h@%0h expected %0h@%0h", data0, addr0, e0[7:0], e0[19:8]);
        end
      end
    end
    if (RST && we1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL wr1_unexpected: got %0h@%0h expected none", data1, addr1);
      end else begin
        logic [19:0] e1;
        e1 = q1.pop_front();
        if ({addr1, data1} !== e1) begin
          errors++;
          $display("FAIL wr1: got %0h@%0h expected %0h@%0h", data1, addr1, e1[7:0], e1[19:8]);
        end
      end
    end
  end

  task automatic do_start();
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0;
  endtask

  // Offer a nibble until accepted (bounded); ok=0 if never accepted
  task automatic offer(input logic [3:0] n, input logic l, input int bound, output logic ok);
    int t;
    @(negedge CLK); nib = n; last = l; vld = 1'b1;
    t = 0;
    while (!rdy && t < bound) begin @(negedge CLK); t++; end
    ok = rdy;
    if (ok) @(negedge CLK);
    vld = 1'b0; last = 1'b0;
  endtask

  task automatic send(input logic [3:0] n, input logic l);
    logic ok;
    offer(n, l, 20, ok);
    chk("nib_accept_timeout", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_end();
    int t;
    t = 0;
    while (busy && t < 30) begin @(negedge CLK); t++; end
    chk("session_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic ok;
    logic [7:0] exp_cs;
`ifdef LOADER_CHECKSUM_EN
    exp_cs = 8'h3F;
`else
    exp_cs = 8'h00;
`endif
    #12;
    chk("rst_ready", {31'd0, rdy0}, 0);
    chk("rst_we",    {31'd0, we0}, 0);
    chk("rst_status", {28'd0, busy0, done0, err0, run0}, 0);
    chk("rst_addr_w", {20'd0, addr1}, 32'hFFE);
    chk("rst_data",  {24'd0, data0}, 0);
    chk("rst_cnt",   {19'd0, cnt0}, 0);
    chk("rst_cs",    {24'd0, cs0}, 0);
    @(negedge CLK); RST = 1'b1;

    // Two-byte session ending in FIN
    q0.push_back({12'h000, 8'h3A});
    q0.push_back({12'h001, 8'h05});
    do_start();
    chk("busy_hi", {31'd0, busy}, 1);
    send(4'h3, 1'b0); send(4'hA, 1'b0); send(4'h0, 1'b0); send(4'h5, 1'b1);
    wait_end();
    chk("fin_status", {29'd0, done, err, run}, 32'b101);
    chk("fin_cnt",  {19'd0, cnt}, 2);
    chk("fin_addr", {20'd0, addr0}, 12'h002);
    chk("fin_cs",   {24'd0, cs0}, {24'd0, exp_cs});

    // Odd nibble count: one byte, then FAIL
    q0.push_back({12'h000, 8'h71});
    do_start();
    chk("restart_clear", {28'd0, done, err, run, busy}, 32'b0001);
    send(4'h7, 1'b0); send(4'h1, 1'b0); send(4'h4, 1'b1);
    repeat (2) @(negedge CLK);
    chk("odd_status", {29'd0, done, err, run}, 32'b010);
    chk("odd_cnt", {19'd0, cnt}, 1);

    // Address overflow on the FFE instance
    sel = 1'b1;
    q1.push_back({12'hFFE, 8'h12});
    q1.push_back({12'hFFF, 8'h34});
    do_start();
    send(4'h1, 1'b0); send(4'h2, 1'b0); send(4'h3, 1'b0); send(4'h4, 1'b0);
    offer(4'h5, 1'b0, 5, ok);
    chk("ovf_nib5_rejected", {31'd0, ok}, 0);
    offer(4'h6, 1'b1, 5, ok);
    chk("ovf_nib6_rejected", {31'd0, ok}, 0);
    chk("ovf_status", {29'd0, done, err, run}, 32'b010);
    chk("ovf_cnt", {19'd0, cnt}, 2);
    sel = 1'b0;

    // Reset one cycle after a high-nibble accept
    do_start();
    send(4'h9, 1'b0);
    RST = 1'b0;
    #1;
    chk("mid_rst_status", {27'd0, rdy0, busy0, done0, err0, run0}, 0);
    chk("mid_rst_we",   {31'd0, we0}, 0);
    chk("mid_rst_addr", {20'd0, addr0}, 0);
    chk("mid_rst_data", {24'd0, data0}, 0);
    chk("mid_rst_cnt",  {19'd0, cnt0}, 0);
    @(negedge CLK); RST = 1'b1;
    nib = 4'h7; vld = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      chk("post_rst_idle", {30'd0, rdy0, busy0}, 0);
    end
    vld = 1'b0;

    // START during LO and VALID held through WRITE
    q0.push_back({12'h000, 8'h3A});
    q0.push_back({12'h001, 8'hCD});
    do_start();
    send(4'h3, 1'b0);
    start = 1'b1; nib = 4'hA; vld = 1'b1;
    @(negedge CLK);
    start = 1'b0; nib = 4'hC;
    chk("write_not_ready", {30'd0, rdy0, busy0}, 32'b01);
    chk("write_strobe", {31'd0, we0}, 1);
    @(negedge CLK);
    chk("hi_ready", {31'd0, rdy0}, 1);
    @(negedge CLK);
    nib = 4'hD; last = 1'b1;
    @(negedge CLK);
    vld = 1'b0; last = 1'b0;
    wait_end();
    chk("hold_status", {29'd0, done, err, run}, 32'b101);
    chk("hold_cnt", {19'd0, cnt}, 2);

    repeat (3) @(negedge CLK);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
